// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_if
//  Purpose  : Byte valid/ready handshake between a byte source and uart_tx.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_tx_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Purpose  : 8N1/8N2 UART transmitter with a one-entry hold register so
//             consecutive bytes go out back-to-back with no idle gap.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8,
  parameter int STOP_BITS    = 1
) (
  input  wire logic clk,
  input  wire logic rst,
  uart_tx_if.slave  bus,
  output logic      tx,
  output logic      busy,
  output logic      tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] C_BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    C_DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0]    C_STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_baud;
  logic [3:0]        r_bit_idx;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_hold;
  logic              r_hold_full;
  logic              r_ready;
  logic              r_tx;
  logic              r_busy;
  logic              r_tx_done;

  logic w_accept;
  logic w_bit_end;
  logic w_stop_end;
  logic w_unload;
  logic w_to_idle;
  logic w_hold_full_nxt;

  assign w_accept   = bus.data_valid && r_ready;
  assign w_bit_end  = (r_baud == C_BAUD_LAST);
  assign w_stop_end = (r_state == S_STOP) && w_bit_end && (r_bit_idx == C_STOP_LAST);
  // The hold register is unloaded either from idle or straight out of the last stop bit.
  assign w_unload   = ((r_state == S_IDLE) || w_stop_end) && r_hold_full;
  assign w_to_idle  = ((r_state == S_IDLE) || w_stop_end) && !r_hold_full;
  assign w_hold_full_nxt = w_accept ? 1'b1 : (w_unload ? 1'b0 : r_hold_full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_baud      <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_ready     <= 1'b1;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_tx_done   <= 1'b0;
    end else begin
      r_tx_done   <= 1'b0;
      r_hold_full <= w_hold_full_nxt;
      r_ready     <= !w_hold_full_nxt;
      r_busy      <= !w_to_idle || w_hold_full_nxt;
      if (w_accept) begin
        r_hold <= bus.data_in;
      end
      if (r_state != S_IDLE) begin
        r_baud <= w_bit_end ? '0 : r_baud + CW'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (r_hold_full) begin
            r_state <= S_START;
            r_shift <= r_hold;
            r_tx    <= 1'b0;
            r_baud  <= '0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state   <= S_DATA;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == C_DATA_LAST) begin
              r_state   <= S_STOP;
              r_bit_idx <= '0;
              r_tx      <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 4'd1;
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
            end
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (r_bit_idx == C_STOP_LAST) begin
              r_tx_done <= 1'b1;
              r_bit_idx <= '0;
              if (r_hold_full) begin
                r_state <= S_START;
                r_shift <= r_hold;
                r_tx    <= 1'b0;
                r_baud  <= '0;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 4'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.data_ready = r_ready;
  assign tx             = r_tx;
  assign busy           = r_busy;
  assign tx_done        = r_tx_done;

endmodule
`default_nettype wire
